// File: rtl/seq_pkg.sv
// Shared constants and the power-on table contents for the programmable sequence counter.
package seq_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DN       = 1'b0;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Default entry i holds i reduced modulo 2^width, so a fresh table counts 0,1,2,...
  function automatic int init_val(input int i, input int width);
    if (width >= 31) return i;
    return i % (1 << width);
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH register table: one synchronous write port and one asynchronous read port.
module seq_table
  import seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  // Addresses past the last entry only exist when DEPTH is not a power of two.
  assign wr_ok = wr_en && (32'(wr_addr) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(init_val(i, WIDTH));
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_seq_counter.sv
// Programmable sequence counter: an index register walks a writable table in either
// direction, wrapping or stopping at the ends; q is the table entry under the index.
module prog_seq_counter
  import seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [IDXW-1:0]  load_idx,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [IDXW-1:0]  idx,
  output logic             tc,
  output logic             done
);

  localparam int unsigned     LAST_U = DEPTH - 1;
  localparam logic [IDXW-1:0] LAST   = IDXW'(LAST_U);

  logic at_last;
  logic at_first;

  assign at_last  = (idx == LAST);
  assign at_first = (idx == '0);

  // A finished one-shot run freezes the index until a load or reset restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      done <= 1'b0;
    end else if (load) begin
      idx  <= (32'(load_idx) > LAST_U) ? LAST : load_idx;
      done <= 1'b0;
    end else if (en && !done) begin
      if (dir == DIR_UP) begin
        if (!at_last) begin
          idx <= idx + IDXW'(1);
        end else if (oneshot == MODE_WRAP) begin
          idx <= '0;
        end else begin
          done <= 1'b1;
        end
      end else begin
        if (!at_first) begin
          idx <= idx - IDXW'(1);
        end else if (oneshot == MODE_WRAP) begin
          idx <= LAST;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

  assign tc = en & (((dir == DIR_UP) & at_last) | ((dir == DIR_DN) & at_first));

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (q)
  );

endmodule

// File: tb/tb_prog_seq_counter.sv
// Bench for prog_seq_counter: a DEPTH=8 and a DEPTH=6 instance share stimulus and are
// compared every cycle against an arithmetic reference model, plus directed expectations.
module tb_prog_seq_counter;

  logic       clk = 1'b0;
  logic       reset, en, dir, oneshot, load, wr_en;
  logic [2:0] load_idx, wr_addr, wr_data;

  logic [2:0] q8, idx8, q6, idx6;
  logic       tc8, done8, tc6, done6;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int depth [2] = '{8, 6};
  int m_idx [2];
  int m_done[2];
  int m_tab [2][8];

  always #5 clk = ~clk;

  prog_seq_counter #(.WIDTH(3), .DEPTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .oneshot(oneshot),
    .load(load), .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .q(q8), .idx(idx8), .tc(tc8), .done(done8)
  );

  prog_seq_counter #(.WIDTH(3), .DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .oneshot(oneshot),
    .load(load), .load_idx(load_idx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .q(q6), .idx(idx6), .tc(tc6), .done(done6)
  );

  task automatic apply_stimulus(input logic r, input logic e, input logic d, input logic o,
                                input logic l, input int li,
                                input logic w, input int wa, input int wd);
    reset    = r;
    en       = e;
    dir      = d;
    oneshot  = o;
    load     = l;
    load_idx = 3'(li);
    wr_en    = w;
    wr_addr  = 3'(wa);
    wr_data  = 3'(wd);
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs held across that edge.
  task automatic model_edge();
    int nxt;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_idx[k]  = 0;
        m_done[k] = 0;
        for (int i = 0; i < 8; i++) m_tab[k][i] = i % 8;
      end else begin
        if (wr_en && int'(wr_addr) < depth[k]) m_tab[k][int'(wr_addr)] = int'(wr_data);
        if (load) begin
          m_idx[k]  = (int'(load_idx) < depth[k]) ? int'(load_idx) : depth[k] - 1;
          m_done[k] = 0;
        end else if (en && m_done[k] == 0) begin
          nxt = dir ? m_idx[k] + 1 : m_idx[k] - 1;
          if (nxt >= 0 && nxt < depth[k]) m_idx[k] = nxt;
          else if (oneshot) m_done[k] = 1;
          else m_idx[k] = (nxt + depth[k]) % depth[k];
        end
      end
    end
  endtask

  function automatic int model_tc(input int k);
    return (en && ((dir && m_idx[k] == depth[k] - 1) || (!dir && m_idx[k] == 0))) ? 1 : 0;
  endfunction

  task automatic check_all();
    check_output("q8",    32'(q8),    32'(m_tab[0][m_idx[0]]));
    check_output("idx8",  32'(idx8),  32'(m_idx[0]));
    check_output("done8", 32'(done8), 32'(m_done[0]));
    check_output("tc8",   32'(tc8),   32'(model_tc(0)));
    check_output("q6",    32'(q6),    32'(m_tab[1][m_idx[1]]));
    check_output("idx6",  32'(idx6),  32'(m_idx[1]));
    check_output("done6", 32'(done6), 32'(m_done[1]));
    check_output("tc6",   32'(tc6),   32'(model_tc(1)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int exp23 [9] = '{1, 4, 6, 3, 2, 0, 5, 7, 1};
    int wr23  [8] = '{1, 4, 6, 3, 2, 0, 5, 7};
    int exp24 [5] = '{2, 1, 0, 0, 0};
    int done24[5] = '{0, 0, 0, 1, 1};

    // Reset state
    apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    #2;
    tick();
    check_output("rst_q8", 32'(q8), 32'd0);
    check_output("rst_idx6", 32'(idx6), 32'd0);

    // Default table, wrapping up-count
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check_output("seq022_tc_idle", 32'(tc8), 32'd0);
    for (int k = 1; k < 10; k++) begin
      tick();
      check_output("seq022_q", 32'(q8), 32'(k % 8));
      check_output("seq022_tc", 32'(tc8), (k % 8 == 7) ? 32'd1 : 32'd0);
    end

    // Program a custom table, then load 0 and walk it
    for (int a = 0; a < 8; a++) begin
      apply_stimulus(0, 0, 1, 0, 0, 0, 1, a, wr23[a]);
      tick();
    end
    apply_stimulus(0, 0, 1, 0, 1, 0, 0, 0, 0);
    tick();
    check_output("seq023_q", 32'(q8), 32'(exp23[0]));
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 9; k++) begin
      tick();
      check_output("seq023_q", 32'(q8), 32'(exp23[k]));
    end

    // One-shot down-count from 2 stops at 0 and raises done
    apply_stimulus(0, 1, 0, 1, 1, 2, 0, 0, 0);
    tick();
    check_output("seq024_idx", 32'(idx8), 32'(exp24[0]));
    check_output("seq024_done", 32'(done8), 32'(done24[0]));
    apply_stimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k < 5; k++) begin
      tick();
      check_output("seq024_idx", 32'(idx8), 32'(exp24[k]));
      check_output("seq024_done", 32'(done8), 32'(done24[k]));
    end
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check_output("seq024_sticky_done", 32'(done8), 32'd1);
    check_output("seq024_sticky_idx", 32'(idx8), 32'd0);
    apply_stimulus(0, 0, 1, 0, 1, 5, 0, 0, 0);
    tick();
    check_output("seq024_reload_idx", 32'(idx8), 32'd5);
    check_output("seq024_reload_done", 32'(done8), 32'd0);

    // Load, step enable and a write to the loaded entry in the same cycle
    apply_stimulus(0, 1, 1, 0, 1, 3, 1, 3, 6);
    tick();
    check_output("seq025_idx", 32'(idx8), 32'd3);
    check_output("seq025_q", 32'(q8), 32'd6);
    check_output("seq025_q6", 32'(q6), 32'd6);
    apply_stimulus(0, 0, 1, 0, 1, 7, 0, 0, 0);
    tick();
    check_output("seq025_clamp6", 32'(idx6), 32'd5);
    check_output("seq025_noclamp8", 32'(idx8), 32'd7);

    // Reset mid-sequence discards a coincident write and restores the table
    apply_stimulus(0, 0, 1, 0, 1, 4, 0, 0, 0);
    tick();
    apply_stimulus(1, 1, 1, 0, 0, 0, 1, 4, 1);
    tick();
    check_output("seq026_idx", 32'(idx8), 32'd0);
    check_output("seq026_q", 32'(q8), 32'd0);
    check_output("seq026_done", 32'(done8), 32'd0);
    apply_stimulus(0, 0, 1, 0, 1, 4, 0, 0, 0);
    tick();
    check_output("seq026_restored", 32'(q8), 32'd4);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      apply_stimulus($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                     1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      tick();
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_seq_counter.md
PROG_SEQ_COUNTER -- requirements
Module: prog_seq_counter

Interface
REQ-001 Parameter WIDTH, default 3: bit width of each sequence value and of output q.
REQ-002 Parameter DEPTH, default 8: number of sequence entries, legal range 2..256.
REQ-003 Parameter IDXW, default $clog2(DEPTH): width of the index buses.
REQ-004 Ports SHALL be, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  step enable.
- dir  in  1  step direction: 1 = up (index +1), 0 = down (index -1).
- oneshot  in  1  mode: 0 = wrap at sequence end, 1 = stop at sequence end.
- load  in  1  load the index from load_idx.
- load_idx  in  IDXW  index value to load.
- wr_en  in  1  write one sequence table entry.
- wr_addr  in  IDXW  table entry to write.
- wr_data  in  WIDTH  value to write.
- q  out  WIDTH  current sequence value, equal to table[idx].
- idx  out  IDXW  current index register.
- tc  out  1  terminal count: the next step wraps.
- done  out  1  one-shot run has finished.

Function
REQ-005 q SHALL be table[idx] read from registered state only; no input-to-q combinational path.
REQ-006 Per rising edge, priority SHALL be reset > load > step. A step occurs when en=1 and the counter is not stopped.
REQ-007 On load=1, idx SHALL take min(load_idx, DEPTH-1) and done SHALL clear, regardless of en.
REQ-008 On a step with dir=1, idx SHALL go to idx+1. When idx=DEPTH-1:
- oneshot=0: idx goes to 0.
- oneshot=1: idx holds and done sets.
REQ-009 On a step with dir=0, idx SHALL go to idx-1. When idx=0:
- oneshot=0: idx goes to DEPTH-1.
- oneshot=1: idx holds and done sets.
REQ-010 tc SHALL be combinational and equal en & ((dir & idx==DEPTH-1) | (~dir & idx==0)), in either mode.
REQ-011 While done=1, steps SHALL be ignored and idx SHALL hold. done SHALL clear only on load or reset. Changing dir or oneshot SHALL NOT clear done.
REQ-012 If oneshot=0 while done=1, done SHALL stay set until a load.
REQ-013 wr_en=1 SHALL write wr_data into table[wr_addr] at the clock edge. Writes with wr_addr >= DEPTH SHALL be ignored.
REQ-014 Writes SHALL be independent of the counter. If wr_addr equals the post-edge idx, q SHALL show the new value in the following cycle.
REQ-015 Non-power-of-two DEPTH: idx SHALL never hold a value >= DEPTH.

Reset
REQ-016 On reset=1 at a clock edge, the block SHALL set:
- idx=0, done=0.
- table[i] = i mod 2^WIDTH for every i, so q=0 in the cycle after reset.
REQ-017 Reset SHALL override load, en and wr_en in the same cycle. A write coincident with reset SHALL be lost.
REQ-018 tc SHALL follow REQ-010 during reset, with idx=0 from the first cycle after the reset edge.

Structure
REQ-019 The shared package seq_pkg SHALL hold:
- the direction constants DIR_UP and DIR_DN;
- the mode constants MODE_WRAP and MODE_ONESHOT;
- the default-table function init_val(i, WIDTH).
REQ-020 The table SHALL be one sub-module, seq_table: DEPTH x WIDTH registers with one synchronous write port, one asynchronous read port at idx, and synchronous reset to init_val.
REQ-021 The index/done control logic SHALL live in prog_seq_counter.

Verification
REQ-022 Default table, reset then en=1, dir=1, oneshot=0 for 10 cycles -> q = 0,1,...,7,0,1; tc=1 exactly while idx=7.
REQ-023 Write table = {1,4,6,3,2,0,5,7} at addrs 0..7, reset off, load idx 0, step up 8 times -> q = 1,4,6,3,2,0,5,7,1.
REQ-024 oneshot=1, dir=0, load_idx=2, en=1 for 5 cycles -> idx = 2,1,0,0,0; done=1 from the cycle after idx first reaches 0 with en=1; a subsequent load_idx=5 -> idx=5, done=0.
REQ-025 Same cycle, load=1 with load_idx=3, en=1, wr_en=1 with wr_addr=3 and wr_data=6 -> next cycle idx=3, q=6; with DEPTH=6, load_idx=7 -> idx=5.
REQ-026 Mid-sequence at idx=4 with a pending write, assert reset -> next cycle idx=0, q=0, done=0, table restored to the default, the pending write lost.
